ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage: pops 42-bit decoded entries from the ID->EX FIFO and performs the ALU op.
//  Writes the 16-bit result back to the async register file and updates condition flags.
//  Issues motor commands (left/right/stop/continue) and evaluates the obstacle/velocity ops.
//  Entry layout: [41] rsvd(0), [40:25] B, [24:9] A, [8:4] opcode, [3:0] rd.
// PARAMETERS
//  DW      16  datapath width (A, B, result)
//  RW      4   register address width
//  FIFO_W  42  FIFO entry width; must equal 2*DW+5+RW+1
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-high reset
//  fifo_rd_data   in   42  FIFO head entry (first-word-fall-through)
//  fifo_rd_valid  in   1   FIFO not empty; fifo_rd_data valid
//  fifo_rd_en     out  1   pop strobe (combinational)
//  wb_en          out  1   register-file write strobe, 1-cycle pulse
//  wb_addr        out  4   writeback register
//  wb_data        out  16  writeback value
//  flag_z/n/c     out  1   zero / negative / carry-or-borrow flags
//  flag_obst      out  1   obstacle flag (last OB_CHECK)
//  motor_cmd      out  2   00 stop, 01 left, 10 right, 11 continue
//  motor_vld      out  1   motor_cmd valid, 1-cycle pulse
//  illegal_op     out  1   1-cycle pulse: unknown opcode popped
//  busy           out  1   multi-cycle op in flight
// BEHAVIOUR
//  - Reset: all registered outputs 0, state IDLE. Reset mid-DIV aborts it; no writeback.
//  - FSM: IDLE, DIV. fifo_rd_en = fifo_rd_valid && state==IDLE && !reset.
//  - IDLE + pop of a single-cycle op: result registered at the pop edge.
//    wb_en/motor_vld/illegal_op are high in the next cycle only.
//    Throughput is 1 entry/cycle.
//  - Ops (A, B unsigned 16b, results truncated to 16b):
//    MOV->A; ADD->A+B; SUB->A-B; AND/OR; NOT->~A; MULT->(A*B)[15:0].
//    CMP: flags only, no wb.
//    OB_CHECK: wb {15'b0, A<B}; flag_obst<=A<B.
//    VELOCITY_GUARD: wb min(A,B), i.e. clamp A to the limit B.
//    MOVE_LEFT/RIGHT/STOP/CONTINUE: motor_vld pulse, no wb.
//  - Flags: only ADD/SUB/CMP update z/n/c; all other ops hold them.
//    z = result==0; n = result[15]; c = ADD carry-out, SUB/CMP borrow (A<B).
//  - Unknown opcode (includes ID's all-zero default entry): popped, discarded, illegal_op pulse.
//    wb_en stays low.
//  - DIV: pop -> DIV state, busy=1, no pops.
//    Restoring divider runs 16 iterations; wb of quotient is high 17 cycles after the pop.
//    Then return to IDLE; the next pop may occur in that wb cycle.
//  - Divide by zero: quotient 16'hFFFF, same latency, flags unchanged.
//  - fifo_rd_valid low: no pop, outputs' strobes low, all registers hold.
//  - The rd field passes through unmodified as wb_addr; no register-0 special case.
// CONFIGURATION
//  EX_DIV_EN defined: DIV uses the iterative divider as described above.
//  EX_DIV_EN undefined: DIV is single-cycle; it writes 16'h0000 to rd and pulses illegal_op.
//   The divider is not instantiated and the DIV state is unreachable.
// STRUCTURE
//  - Shared cpu_pkg holds:
//    op_e (values mirror `OP_* in defines.v);
//    the id_ex_entry_t packed struct {rsvd, b, a, opcode, rd};
//    motor_cmd_e; the DW/RW localparams.
//  - Sub-module ex_divider (start, a, b -> done, q; 16-cycle restoring):
//    instantiated only under EX_DIV_EN.
//  - ALU and the flag logic stay inline.
// TESTING
//  1 ADD A=16'hFFFF B=1 rd=3 -> next cycle wb_en=1, wb_addr=3, wb_data=0; z=1, c=1, n=0.
//  2 Back-to-back SUB 5-7 then MOV A=9, FIFO always valid.
//    Two consecutive wb pulses: 16'hFFFE (n=1, c=1), then 9 (flags held).
//  3 DIV A=100 B=7 rd=2 under EX_DIV_EN:
//    busy for 16 cycles, fifo_rd_en low throughout, wb_data=14 at pop+17.
//    DIV B=0 -> wb_data=16'hFFFF.
//  4 OB_CHECK A=20 B=50 -> wb 1, flag_obst=1.
//    VELOCITY_GUARD A=80 B=60 -> wb 60.
//    MOVE_RIGHT -> motor_cmd=10, motor_vld pulse, wb_en=0.
//  5 Entry with an unknown opcode -> popped, illegal_op pulse, no wb, flags unchanged.
//  6 Assert reset at the 8th DIV iteration -> outputs 0, IDLE, no wb.
//    The next entry is popped normally after reset deasserts.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, ID->EX FIFO entry layout,
// motor command encoding and execute-stage FSM states.
package cpu_pkg;

  localparam int DW     = 16;
  localparam int RW     = 4;
  localparam int OPW    = 5;
  localparam int FIFO_W = 2*DW + OPW + RW + 1;

  // Opcode values mirror the OP_* defines; 0 is the decoder's empty entry
  typedef enum logic [OPW-1:0] {
    OP_MOV            = 5'd1,
    OP_ADD            = 5'd2,
    OP_SUB            = 5'd3,
    OP_AND            = 5'd4,
    OP_OR             = 5'd5,
    OP_NOT            = 5'd6,
    OP_MULT           = 5'd7,
    OP_DIV            = 5'd8,
    OP_CMP            = 5'd9,
    OP_OB_CHECK       = 5'd10,
    OP_VELOCITY_GUARD = 5'd11,
    OP_MOVE_LEFT      = 5'd12,
    OP_MOVE_RIGHT     = 5'd13,
    OP_MOVE_STOP      = 5'd14,
    OP_MOVE_CONTINUE  = 5'd15
  } op_e;

  typedef enum logic [1:0] {
    MOTOR_STOP     = 2'b00,
    MOTOR_LEFT     = 2'b01,
    MOTOR_RIGHT    = 2'b10,
    MOTOR_CONTINUE = 2'b11
  } motor_cmd_e;

  typedef struct packed {
    logic            rsvd;
    logic [DW-1:0]   b;
    logic [DW-1:0]   a;
    logic [OPW-1:0]  opcode;
    logic [RW-1:0]   rd;
  } id_ex_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } ex_state_e;

  // Unsigned minimum, used to clamp a velocity to its limit
  function automatic logic [DW-1:0] umin(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// 16-iteration restoring divider. The first iteration is folded into the
// start edge so the quotient is valid (done pulse) 15 cycles after start.
// Divide by zero naturally yields an all-ones quotient.
module ex_divider
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] q
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0]   rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q, done_q;
  logic [2*DW-1:0] first_step, next_step;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  function automatic logic [2*DW-1:0] div_step(input logic [DW-1:0] rem,
                                               input logic [DW-1:0] quo,
                                               input logic [DW-1:0] dvs);
    logic [DW:0]   sh;
    logic [DW-1:0] tr;
    sh = {rem, quo[DW-1]};
    tr = sh[DW-1:0] - dvs;
    if (sh >= {1'b0, dvs}) div_step = {tr, quo[DW-2:0], 1'b1};
    else                   div_step = {sh[DW-1:0], quo[DW-2:0], 1'b0};
  endfunction

  assign first_step = div_step('0, a, b);
  assign next_step  = div_step(rem_q, quo_q, dvs_q);

  // Iteration counter and completion pulse; reset aborts a division
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        run_q <= 1'b1;
        cnt_q <= CW'(1);
      end else if (run_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(DW-1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Partial remainder / quotient shift register
  always_ff @(posedge clk) begin
    if (start) begin
      {rem_q, quo_q} <= first_step;
      dvs_q          <= b;
    end else if (run_q) begin
      {rem_q, quo_q} <= next_step;
    end
  end

  assign done = done_q;
  assign q    = quo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: pops decoded entries, runs the ALU / robot ops, writes back
// to the register file, maintains condition flags and issues motor commands.
// Build option EX_DIV_EN: when defined, DIV uses the iterative divider
// (17-cycle writeback); otherwise DIV writes 0 and flags illegal_op.
module ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FIFO_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_valid,
  output logic              fifo_rd_en,
  output logic              wb_en,
  output logic [RW-1:0]     wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_obst,
  output logic [1:0]        motor_cmd,
  output logic              motor_vld,
  output logic              illegal_op,
  output logic              busy
);

  id_ex_entry_t ent;
  ex_state_e    state_q;
  logic         pop;
  logic         unused_rsvd;

  logic [DW:0]   sum, diff;
  logic [DW-1:0] alu_res;
  logic          do_wb, upd_flags, c_new, upd_obst, upd_motor, bad_op;
  motor_cmd_e    motor_new;

  logic          wb_en_q, motor_vld_q, illegal_q;
  logic [RW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;
  logic          z_q, n_q, c_q, obst_q;
  motor_cmd_e    motor_cmd_q;

`ifdef EX_DIV_EN
  logic          div_go, div_done;
  logic [DW-1:0] div_quo;
  logic [RW-1:0] div_rd_q;
`endif

  assign ent         = fifo_rd_data;
  assign unused_rsvd = ent.rsvd;
  assign pop         = fifo_rd_valid && (state_q == ST_IDLE);
  assign fifo_rd_en  = pop && !reset;

  // ALU and op decode for the entry at the FIFO head
  always_comb begin
    sum       = {1'b0, ent.a} + {1'b0, ent.b};
    diff      = {1'b0, ent.a} - {1'b0, ent.b};
    alu_res   = '0;
    do_wb     = 1'b0;
    upd_flags = 1'b0;
    c_new     = 1'b0;
    upd_obst  = 1'b0;
    upd_motor = 1'b0;
    motor_new = MOTOR_STOP;
    bad_op    = 1'b0;
`ifdef EX_DIV_EN
    div_go    = 1'b0;
`endif
    case (ent.opcode)
      OP_MOV:  begin alu_res = ent.a;           do_wb = 1'b1; end
      OP_ADD:  begin alu_res = sum[DW-1:0];     do_wb = 1'b1; upd_flags = 1'b1; c_new = sum[DW];  end
      OP_SUB:  begin alu_res = diff[DW-1:0];    do_wb = 1'b1; upd_flags = 1'b1; c_new = diff[DW]; end
      OP_CMP:  begin alu_res = diff[DW-1:0];                  upd_flags = 1'b1; c_new = diff[DW]; end
      OP_AND:  begin alu_res = ent.a & ent.b;   do_wb = 1'b1; end
      OP_OR:   begin alu_res = ent.a | ent.b;   do_wb = 1'b1; end
      OP_NOT:  begin alu_res = ~ent.a;          do_wb = 1'b1; end
      OP_MULT: begin alu_res = ent.a * ent.b;   do_wb = 1'b1; end
      OP_DIV: begin
`ifdef EX_DIV_EN
        div_go = 1'b1;
`else
        alu_res = '0;
        do_wb   = 1'b1;
        bad_op  = 1'b1;
`endif
      end
      OP_OB_CHECK: begin
        // diff[DW] is the borrow of A-B, i.e. A < B
        alu_res  = {{(DW-1){1'b0}}, diff[DW]};
        do_wb    = 1'b1;
        upd_obst = 1'b1;
      end
      OP_VELOCITY_GUARD: begin alu_res = umin(ent.a, ent.b); do_wb = 1'b1; end
      OP_MOVE_LEFT:      begin upd_motor = 1'b1; motor_new = MOTOR_LEFT;     end
      OP_MOVE_RIGHT:     begin upd_motor = 1'b1; motor_new = MOTOR_RIGHT;    end
      OP_MOVE_STOP:      begin upd_motor = 1'b1; motor_new = MOTOR_STOP;     end
      OP_MOVE_CONTINUE:  begin upd_motor = 1'b1; motor_new = MOTOR_CONTINUE; end
      default:           bad_op = 1'b1;
    endcase
  end

`ifdef EX_DIV_EN
  ex_divider u_div (
    .clk   (clk),
    .reset (reset),
    .start (pop && div_go),
    .a     (ent.a),
    .b     (ent.b),
    .done  (div_done),
    .q     (div_quo)
  );
`endif

  // FSM plus registered writeback, flags, motor and strobe outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      obst_q      <= 1'b0;
      motor_cmd_q <= MOTOR_STOP;
      motor_vld_q <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef EX_DIV_EN
      div_rd_q    <= '0;
`endif
    end else begin
      wb_en_q     <= 1'b0;
      motor_vld_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (pop) begin
`ifdef EX_DIV_EN
          if (div_go) begin
            state_q  <= ST_DIV;
            div_rd_q <= ent.rd;
          end
`endif
          if (do_wb) begin
            wb_en_q   <= 1'b1;
            wb_addr_q <= ent.rd;
            wb_data_q <= alu_res;
          end
          if (upd_flags) begin
            z_q <= (alu_res == '0);
            n_q <= alu_res[DW-1];
            c_q <= c_new;
          end
          if (upd_obst) obst_q <= diff[DW];
          if (upd_motor) begin
            motor_cmd_q <= motor_new;
            motor_vld_q <= 1'b1;
          end
          illegal_q <= bad_op;
        end
      end
`ifdef EX_DIV_EN
      else if (div_done) begin
        // Writeback and return to IDLE on the same edge, so the next
        // entry can pop during the writeback cycle
        state_q   <= ST_IDLE;
        wb_en_q   <= 1'b1;
        wb_addr_q <= div_rd_q;
        wb_data_q <= div_quo;
      end
`endif
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign flag_z     = z_q;
  assign flag_n     = n_q;
  assign flag_c     = c_q;
  assign flag_obst  = obst_q;
  assign motor_cmd  = motor_cmd_q;
  assign motor_vld  = motor_vld_q;
  assign illegal_op = illegal_q;
  assign busy       = (state_q == ST_DIV);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by a
// randomized op stream, checked against an arithmetic reference model.
module tb_ex_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [FIFO_W-1:0] fifo_rd_data;
  logic              fifo_rd_valid;
  logic              fifo_rd_en, wb_en, flag_z, flag_n, flag_c, flag_obst;
  logic              motor_vld, illegal_op, busy;
  logic [RW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic [1:0]        motor_cmd;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_valid (fifo_rd_valid),
    .fifo_rd_en    (fifo_rd_en),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .flag_c        (flag_c),
    .flag_obst     (flag_obst),
    .motor_cmd     (motor_cmd),
    .motor_vld     (motor_vld),
    .illegal_op    (illegal_op),
    .busy          (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state: architectural values the outputs should show
  logic [15:0] m_data;
  logic [3:0]  m_addr;
  logic        m_z, m_n, m_c, m_obst;
  logic [1:0]  m_mcmd;
  logic        e_wb, e_mv, e_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_data = '0; m_addr = '0; m_z = 0; m_n = 0; m_c = 0; m_obst = 0; m_mcmd = 2'b00;
    e_wb = 0; e_mv = 0; e_ill = 0;
  endtask

  // Effect of one popped entry, from the op definitions in plain arithmetic
  task automatic model_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd);
    longint s;
    int     r;
    e_wb = 0; e_mv = 0; e_ill = 0; r = 0;
    case (op)
      OP_MOV:  begin e_wb = 1; r = int'(a); end
      OP_ADD: begin
        e_wb = 1;
        s = longint'(a) + longint'(b);
        r = int'(s % 65536);
        m_c = (s > 65535); m_z = (r == 0); m_n = (r >= 32768);
      end
      OP_SUB, OP_CMP: begin
        e_wb = (op == OP_SUB);
        r = (int'(a) + 65536 - int'(b)) % 65536;
        m_c = (a < b); m_z = (r == 0); m_n = (r >= 32768);
      end
      OP_AND:  begin e_wb = 1; r = int'(a & b); end
      OP_OR:   begin e_wb = 1; r = int'(a | b); end
      OP_NOT:  begin e_wb = 1; r = 65535 - int'(a); end
      OP_MULT: begin e_wb = 1; r = int'((longint'(a) * longint'(b)) % 65536); end
      OP_DIV: begin
        e_wb = 1;
`ifdef EX_DIV_EN
        r = (b == 0) ? 65535 : int'(a) / int'(b);
`else
        r = 0; e_ill = 1;
`endif
      end
      OP_OB_CHECK:       begin e_wb = 1; r = (a < b) ? 1 : 0; m_obst = (a < b); end
      OP_VELOCITY_GUARD: begin e_wb = 1; r = (a < b) ? int'(a) : int'(b); end
      OP_MOVE_LEFT:      begin e_mv = 1; m_mcmd = 2'b01; end
      OP_MOVE_RIGHT:     begin e_mv = 1; m_mcmd = 2'b10; end
      OP_MOVE_STOP:      begin e_mv = 1; m_mcmd = 2'b00; end
      OP_MOVE_CONTINUE:  begin e_mv = 1; m_mcmd = 2'b11; end
      default:           e_ill = 1;
    endcase
    if (e_wb) begin
      m_data = r[15:0];
      m_addr = rd;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ":wb_en"},      wb_en,      e_wb);
    chk({tag, ":wb_addr"},    wb_addr,    m_addr);
    chk({tag, ":wb_data"},    wb_data,    m_data);
    chk({tag, ":flag_z"},     flag_z,     m_z);
    chk({tag, ":flag_n"},     flag_n,     m_n);
    chk({tag, ":flag_c"},     flag_c,     m_c);
    chk({tag, ":flag_obst"},  flag_obst,  m_obst);
    chk({tag, ":motor_cmd"},  motor_cmd,  m_mcmd);
    chk({tag, ":motor_vld"},  motor_vld,  e_mv);
    chk({tag, ":illegal_op"}, illegal_op, e_ill);
    chk({tag, ":busy"},       busy,       1'b0);
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd);
    fifo_rd_data  = {1'b0, b, a, op, rd};
    fifo_rd_valid = 1'b1;
  endtask

  // Single-cycle op: pop now, result visible in the next cycle
  task automatic single(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input string tag);
    drive(op, a, b, rd);
    #1;
    chk({tag, ":rd_en"}, fifo_rd_en, 1'b1);
    model_op(op, a, b, rd);
    step();
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    fifo_rd_valid = 1'b0;
    fifo_rd_data  = {$urandom, $urandom};
    e_wb = 0; e_mv = 0; e_ill = 0;
    #1;
    chk({tag, ":rd_en"}, fifo_rd_en, 1'b0);
    step();
    check_out(tag);
  endtask

`ifdef EX_DIV_EN
  // Iterative DIV: 16 busy cycles with the FIFO held valid, writeback in
  // the 17th, then the waiting MOV pops in that same writeback cycle
  task automatic div_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd,
                        input string tag);
    logic [15:0] q;
    q = (b == 0) ? 16'hFFFF : 16'(int'(a) / int'(b));
    drive(OP_DIV, a, b, rd);
    #1;
    chk({tag, ":rd_en"}, fifo_rd_en, 1'b1);
    step();
    drive(OP_MOV, 16'h1234, 16'h0000, 4'd5);
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk({tag, ":busy"},     busy,       1'b1);
      chk({tag, ":rd_en_lo"}, fifo_rd_en, 1'b0);
      chk({tag, ":wb_early"}, wb_en,      1'b0);
      step();
    end
    m_data = q; m_addr = rd; e_wb = 1; e_mv = 0; e_ill = 0;
    check_out({tag, ":wb"});
    chk({tag, ":rd_en_wb"}, fifo_rd_en, 1'b1);
    single(OP_MOV, 16'h1234, 16'h0000, 4'd5, {tag, ":next"});
  endtask
`endif

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    reset         = 1'b1;
    fifo_rd_valid = 1'b1;
    fifo_rd_data  = {1'b0, 16'd1, 16'd2, 5'(OP_ADD), 4'd1};
    #2;
    chk("reset:rd_en", fifo_rd_en, 1'b0);
    check_out("reset");
    step();
    check_out("reset_hold");
    reset = 1'b0;
    idle("idle0");

    // 1: ADD wraps to zero with carry
    single(OP_ADD, 16'hFFFF, 16'h0001, 4'd3, "t1_add");
    chk("t1:wb_data_lit", wb_data, 16'h0000);
    chk("t1:z_lit", flag_z, 1'b1);
    chk("t1:c_lit", flag_c, 1'b1);

    // 2: back-to-back SUB then MOV with FIFO always valid
    single(OP_SUB, 16'd5, 16'd7, 4'd4, "t2_sub");
    chk("t2:sub_lit", wb_data, 16'hFFFE);
    single(OP_MOV, 16'd9, 16'd0, 4'd6, "t2_mov");
    chk("t2:mov_lit", wb_data, 16'd9);
    chk("t2:n_held", flag_n, 1'b1);

    // 3: divide
`ifdef EX_DIV_EN
    div_op(16'd100, 16'd7, 4'd2, "t3_div");
    div_op(16'd100, 16'd0, 4'd2, "t3_div0");
`else
    single(OP_DIV, 16'd100, 16'd7, 4'd2, "t3_div_off");
`endif

    // 4: robot ops
    single(OP_OB_CHECK, 16'd20, 16'd50, 4'd7, "t4_ob");
    chk("t4:ob_lit", wb_data, 16'd1);
    single(OP_VELOCITY_GUARD, 16'd80, 16'd60, 4'd8, "t4_vg");
    chk("t4:vg_lit", wb_data, 16'd60);
    single(OP_MOVE_RIGHT, 16'd0, 16'd0, 4'd1, "t4_right");
    chk("t4:mcmd_lit", motor_cmd, 2'b10);

    // 5: unknown opcodes, including the all-zero entry
    single(5'd20, 16'h1111, 16'h2222, 4'd9, "t5_unk");
    single(5'd0, 16'h0000, 16'h0000, 4'd0, "t5_zero");
    idle("t5_idle");

    // 6: reset in the middle of a division
`ifdef EX_DIV_EN
    drive(OP_DIV, 16'd1000, 16'd3, 4'd9);
    #1;
    chk("t6:rd_en", fifo_rd_en, 1'b1);
    step();
    for (int k = 1; k <= 7; k++) begin
      chk("t6:busy", busy, 1'b1);
      step();
    end
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6:rd_en_rst", fifo_rd_en, 1'b0);
    check_out("t6_rst");
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) idle("t6_nowb");
    single(OP_ADD, 16'd3, 16'd4, 4'd10, "t6_after");
`else
    reset = 1'b1;
    #1;
    model_reset();
    check_out("t6_rst");
    step();
    reset = 1'b0;
    idle("t6_idle");
    single(OP_ADD, 16'd3, 16'd4, 4'd10, "t6_after");
`endif

    // Randomized op stream with occasional FIFO-empty cycles
    for (int i = 0; i < 80; i++) begin
      logic [4:0]  op;
      logic [15:0] a, b;
      logic [3:0]  rd;
      op = 5'($urandom_range(0, 17));
      a  = rnd_val();
      b  = rnd_val();
      rd = 4'($urandom);
      if ($urandom_range(0, 4) == 0) idle("rnd_idle");
`ifdef EX_DIV_EN
      if (op == OP_DIV) div_op(a, b, rd, "rnd_div");
      else              single(op, a, b, rd, "rnd");
`else
      single(op, a, b, rd, "rnd");
`endif
    end
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
